// File: rtl/fp_normalize_round_if.sv
// rtl/fp_normalize_round_if.sv - handshake bundle for the binary32 normalise/round stage
//
// Purpose: groups the raw-sum input stream and the packed-result output stream
// of fp_normalize_round into one interface.
//   master : the environment side (drives the raw sum and out_rdy)
//   slave  : the fp_normalize_round side (drives in_rdy and the result)
// Signals:
//   sum_sign, sum_exp[EXP_W], sum_mant[MANT_W], in_state[2], in_vld -> in_rdy
//   result[32], state[2], res_vld -> out_rdy
interface fp_normalize_round_if #(
  parameter int MANT_W = 28,
  parameter int EXP_W  = 8
);
  logic              sum_sign;
  logic [EXP_W-1:0]  sum_exp;
  logic [MANT_W-1:0] sum_mant;
  logic [1:0]        in_state;
  logic              in_vld;
  logic              in_rdy;
  logic [31:0]       result;
  logic [1:0]        state;
  logic              res_vld;
  logic              out_rdy;

  modport master (
    output sum_sign, sum_exp, sum_mant, in_state, in_vld, out_rdy,
    input  in_rdy, result, state, res_vld
  );

  modport slave (
    input  sum_sign, sum_exp, sum_mant, in_state, in_vld, out_rdy,
    output in_rdy, result, state, res_vld
  );
endinterface

// File: rtl/fp_normalize_round.sv
// rtl/fp_normalize_round.sv - normalise, round-to-nearest-even and pack binary32 sums
//
// Purpose: last stage of the single-precision adder. Stage 1 normalises the
// raw aligned mantissa, stage 2 rounds (RNE) and packs the IEEE-754 word plus
// a 2-bit status tag (00 OK, 01 NAN, 10 INF, 11 NUL).
// Ports:
//   clk  : clock
//   rst  : synchronous active-low reset
//   bus  : fp_normalize_round_if.slave
//          in : sum_sign, sum_exp, sum_mant ([27] carry, [26] hidden,
//               [25:3] fraction, [2] guard, [1] round, [0] sticky),
//               in_state, in_vld / in_rdy
//          out: result, state, res_vld / out_rdy
// Build option: define FPU_NORM_DENORM_EN to produce subnormals on underflow;
// otherwise underflow flushes to signed zero with state NUL.
module fp_normalize_round #(
  parameter int MANT_W = 28,
  parameter int EXP_W  = 8
) (
  input logic                 clk,
  input logic                 rst,
  fp_normalize_round_if.slave bus
);

  localparam int IEW = EXP_W + 2;           // signed internal exponent
  localparam int NW  = MANT_W - 1;          // normalised mantissa: hidden..sticky
  localparam int LZW = $clog2(MANT_W);

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_NAN = 2'b01;
  localparam logic [1:0] ST_INF = 2'b10;
  localparam logic [1:0] ST_NUL = 2'b11;

  localparam logic signed [IEW-1:0] EXP_INF  = IEW'((1 << EXP_W) - 1);
  localparam logic signed [IEW-1:0] EXP_ZERO = '0;

  // Pipeline control
  logic s1_vld;
  logic adv1, adv2;

  assign adv2       = !bus.res_vld || bus.out_rdy;
  assign adv1       = !s1_vld || adv2;
  assign bus.in_rdy = adv1;

  // Stage 1: normalise
  logic [LZW-1:0]        lzc;
  logic [NW-1:0]         n_mant;
  logic signed [IEW-1:0] n_exp;
  logic                  n_zero;

  always_comb begin
    lzc    = '0;
    n_zero = 1'b0;
    n_mant = bus.sum_mant[NW-1:0];
    n_exp  = {2'b00, bus.sum_exp};
    // Highest set bit wins because the scan runs upward.
    for (int i = 0; i < NW; i++) begin
      if (bus.sum_mant[i]) lzc = LZW'(NW - 1 - i);
    end
    if (bus.sum_mant[MANT_W-1]) begin
      // Carry out of the add: drop one bit into sticky.
      n_mant = {bus.sum_mant[MANT_W-1:2], |bus.sum_mant[1:0]};
      n_exp  = n_exp + IEW'(1);
    end else if (bus.sum_mant == '0) begin
      n_zero = 1'b1;
    end else begin
      n_mant = bus.sum_mant[NW-1:0] << lzc;
      n_exp  = n_exp - IEW'(lzc);
    end
  end

  logic                  s1_sign;
  logic signed [IEW-1:0] s1_exp;
  logic [NW-1:0]         s1_mant;
  logic                  s1_zero;
  logic [1:0]            s1_tag;

  always_ff @(posedge clk) begin
    if (adv1) begin
      s1_sign <= bus.sum_sign;
      s1_exp  <= n_exp;
      s1_mant <= n_mant;
      s1_zero <= n_zero;
      s1_tag  <= bus.in_state;
    end
  end

  // Stage 2: round to nearest even
  logic                  round_up;
  logic [24:0]           r_sum;
  logic [22:0]           r_frac;
  logic signed [IEW-1:0] r_exp;

  always_comb begin
    round_up = s1_mant[2] & (s1_mant[1] | s1_mant[0] | s1_mant[3]);
    r_sum    = {1'b0, s1_mant[NW-1:3]} + {24'b0, round_up};
    if (r_sum[24]) begin
      r_frac = r_sum[23:1];
      r_exp  = s1_exp + IEW'(1);
    end else begin
      r_frac = r_sum[22:0];
      r_exp  = s1_exp;
    end
  end

`ifdef FPU_NORM_DENORM_EN
  // Subnormal path: denormalise the pre-rounding mantissa so that only one
  // rounding step is applied to the final value.
  logic [IEW-1:0] d_sh_raw;
  logic [LZW-1:0] d_sh;
  logic [NW-1:0]  d_full;
  logic [NW-1:0]  d_mant;
  logic           d_lost;
  logic           d_up;
  logic [23:0]    d_sum;

  always_comb begin
    d_sh_raw = IEW'(1) - s1_exp;
    d_sh     = (d_sh_raw > IEW'(NW)) ? LZW'(NW) : d_sh_raw[LZW-1:0];
    d_full   = s1_mant >> d_sh;
    d_lost   = |(s1_mant & ~({NW{1'b1}} << d_sh));
    d_mant   = {d_full[NW-1:1], d_full[0] | d_lost};
    d_up     = d_mant[2] & (d_mant[1] | d_mant[0] | d_mant[3]);
    d_sum    = d_mant[NW-1:3] + {23'b0, d_up};
  end
`endif

  // Packing
  logic [31:0] p_res;
  logic [1:0]  p_state;

  always_comb begin
    p_res   = '0;
    p_state = ST_OK;
    case (s1_tag)
      ST_NAN: begin
        p_res   = 32'h7FC00000;
        p_state = ST_NAN;
      end
      ST_INF: begin
        p_res   = {s1_sign, 8'hFF, 23'h0};
        p_state = ST_INF;
      end
      ST_NUL: begin
        p_res   = {s1_sign, 31'h0};
        p_state = ST_NUL;
      end
      default: begin
        if (s1_zero) begin
          p_res   = 32'h0;
          p_state = ST_NUL;
        end else if (r_exp >= EXP_INF) begin
          p_res   = {s1_sign, 8'hFF, 23'h0};
          p_state = ST_INF;
        end else if (r_exp <= EXP_ZERO) begin
`ifdef FPU_NORM_DENORM_EN
          if (d_sum == '0) begin
            p_res   = {s1_sign, 31'h0};
            p_state = ST_NUL;
          end else begin
            // A carry into bit 23 lands in the exponent LSB: 2^-126.
            p_res   = {s1_sign, 7'b0, d_sum};
            p_state = ST_OK;
          end
`else
          p_res   = {s1_sign, 31'h0};
          p_state = ST_NUL;
`endif
        end else begin
          p_res   = {s1_sign, r_exp[EXP_W-1:0], r_frac};
          p_state = ST_OK;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_vld      <= 1'b0;
      bus.res_vld <= 1'b0;
      bus.result  <= 32'h0;
      bus.state   <= ST_OK;
    end else begin
      if (adv1) s1_vld <= bus.in_vld;
      if (adv2) begin
        bus.res_vld <= s1_vld;
        if (s1_vld) begin
          bus.result <= p_res;
          bus.state  <= p_state;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_normalize_round.sv
// tb/tb_fp_normalize_round.sv - bench for fp_normalize_round
module tb_fp_normalize_round;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  fp_normalize_round_if bus ();

  fp_normalize_round dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Round v / 2^k to nearest, ties to even; negative k is an exact left shift.
  function automatic longint unsigned rne(input longint unsigned v, input int k);
    longint unsigned q, rem, half;
    if (k <= 0) return v << (-k);
    q    = v >> k;
    rem  = v & ((64'd1 << k) - 1);
    half = 64'd1 << (k - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    return q;
  endfunction

  // Value of the raw sum is mant * 2^(exp - 127 - 26); returns {state, result}.
  function automatic logic [33:0] model(input logic s, input logic [7:0] e,
                                        input logic [27:0] m, input logic [1:0] t);
    int p, e0, e1;
    longint unsigned q;
    if (t == 2'b01) return {2'b01, 32'h7FC00000};
    if (t == 2'b10) return {2'b10, s, 8'hFF, 23'h0};
    if (t == 2'b11) return {2'b11, s, 31'h0};
    if (m == 28'h0) return {2'b11, 32'h0};
    p = 27;
    while (m[p] == 1'b0) p--;
    e0 = int'(e) + p - 26;
    q  = rne(64'(m), p - 23);
    e1 = e0;
    if (q >= (64'd1 << 24)) begin
      q  = q >> 1;
      e1 = e1 + 1;
    end
    if (e1 >= 255) return {2'b10, s, 8'hFF, 23'h0};
    if (e1 <= 0) begin
`ifdef FPU_NORM_DENORM_EN
      q = rne(64'(m), p - 23 + 1 - e0);
      if (q == 0) return {2'b11, s, 31'h0};
      return {2'b00, s, q[30:0]};
`else
      return {2'b11, s, 31'h0};
`endif
    end
    return {2'b00, s, e1[7:0], q[22:0]};
  endfunction

  task automatic gen(output logic s, output logic [7:0] e, output logic [27:0] m,
                     output logic [1:0] t);
    int sel;
    s   = 1'($urandom);
    sel = $urandom_range(0, 3);
    if (sel == 0)      e = 8'($urandom_range(0, 30));
    else if (sel == 1) e = 8'($urandom_range(225, 255));
    else               e = 8'($urandom);
    m = 28'($urandom) >> (($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 28));
    t = ($urandom_range(0, 7) < 6) ? 2'b00 : 2'($urandom_range(1, 3));
  endtask

  task automatic drive(input logic s, input logic [7:0] e, input logic [27:0] m,
                       input logic [1:0] t);
    bus.sum_sign = s;
    bus.sum_exp  = e;
    bus.sum_mant = m;
    bus.in_state = t;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.in_vld = 1'b0;
    bus.out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (bus.res_vld !== 1'b0) begin n_fail++; $display("FAIL reset_res_vld: got %b expected 0", bus.res_vld); end
    n_tests++;
    if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 00000000", bus.result); end
    n_tests++;
    if (bus.state !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %b expected 00", bus.state); end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.in_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_in_rdy: got %b expected 1", bus.in_rdy); end
  endtask

  task automatic test_directed();
    logic        v_s[12];
    logic [7:0]  v_e[12];
    logic [27:0] v_m[12];
    logic [1:0]  v_t[12];
    logic [31:0] v_r[12];
    logic [1:0]  v_st[12];
    v_s  = '{0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 1};
    v_e  = '{127, 127, 127, 127, 127, 254, 127, 10, 10, 1, 254, 0};
    v_m  = '{28'h8000000, 28'h400000C, 28'h4000004, 28'h0000008, 28'h0, 28'h8000000,
             28'h0, 28'h1234567, 28'h1234567, 28'h4000000, 28'h7FFFFFC, 28'h4000000};
    v_t  = '{0, 0, 0, 0, 0, 0, 1, 2, 3, 0, 0, 0};
    v_r  = '{32'h40000000, 32'h3F800002, 32'h3F800000, 32'h34000000, 32'h00000000,
             32'hFF800000, 32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h00800000,
             32'h7F800000, 32'h80000000};
    v_st = '{0, 0, 0, 0, 3, 2, 1, 2, 3, 0, 2, 3};
`ifdef FPU_NORM_DENORM_EN
    v_r[11]  = 32'h80400000;
    v_st[11] = 2'b00;
`endif
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(v_s[i], v_e[i], v_m[i], v_t[i]);
      bus.in_vld  = 1'b1;
      bus.out_rdy = 1'b1;
      #1;
      n_tests++;
      if (bus.in_rdy !== 1'b1) begin n_fail++; $display("FAIL dir%0d_in_rdy: got %b expected 1", i, bus.in_rdy); end
      @(negedge clk);
      bus.in_vld = 1'b0;
      n_tests++;
      if (bus.res_vld !== 1'b0) begin n_fail++; $display("FAIL dir%0d_latency_early: res_vld %b expected 0", i, bus.res_vld); end
      @(negedge clk);
      n_tests++;
      if (bus.res_vld !== 1'b1) begin n_fail++; $display("FAIL dir%0d_latency: res_vld %b expected 1", i, bus.res_vld); end
      n_tests++;
      if (bus.result !== v_r[i] || bus.state !== v_st[i])
        begin n_fail++; $display("FAIL dir%0d_value: got %h/%b expected %h/%b", i, bus.result, bus.state, v_r[i], v_st[i]); end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [33:0] q[$];
    logic [33:0] ev;
    logic s;
    logic [7:0] e;
    logic [27:0] m;
    logic [1:0] t;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      bus.out_rdy = 1'b1;
      if (cyc < 6) begin
        gen(s, e, m, t);
        drive(s, e, m, t);
        bus.in_vld = 1'b1;
      end else begin
        bus.in_vld = 1'b0;
      end
      #1;
      n_tests++;
      if (bus.in_rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_in_rdy: cycle %0d got %b expected 1", cyc, bus.in_rdy); end
      n_tests++;
      if (bus.res_vld !== (cyc >= 2)) begin n_fail++; $display("FAIL b2b_res_vld: cycle %0d got %b expected %b", cyc, bus.res_vld, cyc >= 2); end
      if (bus.res_vld === 1'b1 && q.size() > 0) begin
        ev = q.pop_front();
        n_tests++;
        if ({bus.state, bus.result} !== ev) begin n_fail++; $display("FAIL b2b_data: got %b/%h expected %b/%h", bus.state, bus.result, ev[33:32], ev[31:0]); end
      end
      if (bus.in_vld && bus.in_rdy) q.push_back(model(s, e, m, t));
    end
    n_tests++;
    if (q.size() != 0) begin n_fail++; $display("FAIL b2b_drain: %0d results outstanding expected 0", q.size()); end
  endtask

  task automatic test_backpressure();
    logic        a_s[4];
    logic [7:0]  a_e[4];
    logic [27:0] a_m[4];
    logic [1:0]  a_t[4];
    logic [33:0] exp_q[$];
    logic [33:0] ev;
    logic [33:0] held;
    int sent;
    int got;
    sent = 0;
    got  = 0;
    held = '0;
    for (int i = 0; i < 4; i++) begin
      gen(a_s[i], a_e[i], a_m[i], a_t[i]);
      a_t[i] = 2'b00;
      exp_q.push_back(model(a_s[i], a_e[i], a_m[i], a_t[i]));
    end
    for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
      @(negedge clk);
      bus.in_vld = (sent < 4);
      if (sent < 4) drive(a_s[sent], a_e[sent], a_m[sent], a_t[sent]);
      bus.out_rdy = (cyc >= 5);
      #1;
      if (cyc < 2) begin
        n_tests++;
        if (bus.in_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_rdy_open: cycle %0d got %b expected 1", cyc, bus.in_rdy); end
      end
      if (cyc >= 2 && cyc <= 4) begin
        n_tests++;
        if (bus.in_rdy !== 1'b0 || bus.res_vld !== 1'b1)
          begin n_fail++; $display("FAIL bp_stall: cycle %0d in_rdy %b res_vld %b expected 0 1", cyc, bus.in_rdy, bus.res_vld); end
        if (cyc == 2) begin
          held = {bus.state, bus.result};
        end else begin
          n_tests++;
          if ({bus.state, bus.result} !== held) begin n_fail++; $display("FAIL bp_hold: got %h expected %h", {bus.state, bus.result}, held); end
        end
      end
      if (bus.res_vld && bus.out_rdy) begin
        ev = exp_q.pop_front();
        got++;
        n_tests++;
        if ({bus.state, bus.result} !== ev) begin n_fail++; $display("FAIL bp_order: result %0d got %b/%h expected %b/%h", got, bus.state, bus.result, ev[33:32], ev[31:0]); end
      end
      if (bus.in_vld && bus.in_rdy) sent++;
    end
    bus.in_vld = 1'b0;
    n_tests++;
    if (got != 4) begin n_fail++; $display("FAIL bp_count: got %0d results expected 4", got); end
  endtask

  task automatic test_random();
    localparam int N = 400;
    logic [33:0] q[$];
    logic [33:0] ev;
    logic s;
    logic [7:0] e;
    logic [27:0] m;
    logic [1:0] t;
    logic hold;
    int sent;
    int got;
    int cyc;
    sent = 0;
    got  = 0;
    cyc  = 0;
    hold = 1'b0;
    s = 0; e = 0; m = 0; t = 0;
    while ((sent < N || got < N) && cyc < 5000) begin
      @(negedge clk);
      if (!hold) begin
        if (sent < N && $urandom_range(0, 3) != 0) begin
          gen(s, e, m, t);
          drive(s, e, m, t);
          bus.in_vld = 1'b1;
        end else begin
          bus.in_vld = 1'b0;
        end
      end
      bus.out_rdy = ($urandom_range(0, 9) < 7);
      #1;
      if (bus.res_vld && bus.out_rdy) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_spurious: result %h with nothing outstanding", bus.result);
        end else begin
          ev = q.pop_front();
          if ({bus.state, bus.result} !== ev)
            begin n_fail++; $display("FAIL rand_data: item %0d got %b/%h expected %b/%h", got, bus.state, bus.result, ev[33:32], ev[31:0]); end
        end
        got++;
      end
      if (bus.in_vld && bus.in_rdy) begin
        q.push_back(model(s, e, m, t));
        sent++;
        hold = 1'b0;
      end else begin
        hold = bus.in_vld;
      end
      cyc++;
    end
    bus.in_vld = 1'b0;
    n_tests++;
    if (got != N || q.size() != 0) begin n_fail++; $display("FAIL rand_complete: got %0d results expected %0d", got, N); end
  endtask

  task automatic test_reset_midflight();
    logic s;
    logic [7:0] e;
    logic [27:0] m;
    logic [1:0] t;
    @(negedge clk);
    bus.out_rdy = 1'b0;
    gen(s, e, m, t);
    drive(s, e, m, t);
    bus.in_vld = 1'b1;
    @(negedge clk);
    gen(s, e, m, t);
    drive(s, e, m, t);
    @(negedge clk);
    bus.in_vld = 1'b0;
    #1;
    n_tests++;
    if (bus.in_rdy !== 1'b0 || bus.res_vld !== 1'b1)
      begin n_fail++; $display("FAIL mid_full: in_rdy %b res_vld %b expected 0 1", bus.in_rdy, bus.res_vld); end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.res_vld !== 1'b0 || bus.result !== 32'h0 || bus.state !== 2'b00 || bus.in_rdy !== 1'b1)
      begin n_fail++; $display("FAIL mid_reset: res_vld %b result %h state %b in_rdy %b expected 0 00000000 00 1", bus.res_vld, bus.result, bus.state, bus.in_rdy); end
    rst = 1'b1;
    bus.out_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_tests++;
      if (bus.res_vld !== 1'b0) begin n_fail++; $display("FAIL mid_stale: cycle %0d res_vld %b expected 0", i, bus.res_vld); end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    bus.in_vld = 1'b0;
    bus.out_rdy = 1'b0;
    bus.sum_sign = 1'b0;
    bus.sum_exp = '0;
    bus.sum_mant = '0;
    bus.in_state = 2'b00;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_normalize_round.md
Name: fp_normalize_round

Overview:
- Downstream stage of the single-precision floating-point adder.
- Consumes the raw aligned sum: sign, biased exponent, unnormalised 28-bit mantissa with guard/round/sticky bits, and a special-case tag.
- Normalises, rounds to nearest-even and packs an IEEE-754 binary32 word with the 2-bit status code.
- 2-stage pipeline with valid/ready backpressure toward the FPU writeback.

Parameters:
- MANT_W, 28, raw mantissa width: [27] carry, [26] hidden, [25:3] fraction, [2] guard, [1] round, [0] sticky.
- EXP_W, 8, biased exponent width of input and output.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-low reset.
- sum_sign  input  1  sign of raw sum.
- sum_exp  input  EXP_W  biased exponent of raw sum, before normalisation.
- sum_mant  input  MANT_W  raw mantissa, layout as MANT_W.
- in_state  input  2  upstream tag: 00 OK, 01 NAN, 10 INF, 11 NUL.
- in_vld  input  1  input valid.
- in_rdy  output  1  input accepted when in_vld && in_rdy.
- result  output  32  packed binary32 result.
- state  output  2  result tag, same encoding as in_state.
- res_vld  output  1  result valid.
- out_rdy  input  1  consumer accepts result when res_vld && out_rdy.

Behaviour:
- Reset (rst==0 at posedge): both stage valids cleared; result=32'h0, state=2'b00, res_vld=0.
  - in_rdy=1 in the first cycle after reset.
  - Reset mid-operation discards all in-flight entries.
- Pipeline advance:
  - adv2 = !res_vld || out_rdy.
  - adv1 = !s1_vld || adv2.
  - in_rdy = adv1 (combinational).
- Latency: 2 cycles, input accept edge to res_vld, when unstalled. Throughput 1/cycle.
- While res_vld && !out_rdy, result and state are held stable.
- Stage 1 (normalise), internal exponent 10-bit signed:
  - mant[27]=1: shift right 1; exp+1; sticky |= dropped bit.
  - mant==0: mark exact zero.
  - Otherwise: lzc = leading zeros of mant[26:0]; shift left lzc; exp-lzc.
- Stage 2 (round):
  - round_up = G & (R | S | LSB).
  - Increment the 24-bit significand.
  - Carry-out: shift right 1, exp+1.
- Packing when in_state==OK:
  - exp>=255 → result {sign,8'hFF,23'h0}, state INF.
  - exp<=0 → flush: result {sign,31'h0}, state NUL.
  - Exact zero → result 32'h00000000 (+0), state NUL.
  - Else {sign,exp[7:0],frac[22:0]}, state OK.
- Special tags bypass the arithmetic but follow the same 2-cycle pipeline:
  - NAN → 32'h7FC00000, state NAN.
  - INF → {sum_sign,8'hFF,23'h0}, state INF.
  - NUL → {sum_sign,31'h0}, state NUL.
- Simultaneous accept and output handshake in the same cycle: both occur, no bubble, no loss.

Optional Feature:
- FPU_NORM_DENORM_EN
- Defined: exp<=0 after rounding produces a subnormal.
  - Significand shifted right by (1-exp), sticky-ORed, rounded RNE.
  - Exponent field 0, state OK.
  - State NUL only if the rounded value is 0.
  - Rounding up to 2^-126 yields exponent field 1.
- Undefined: flush-to-zero as in Behaviour, state NUL.

Test Plan:
- 2.0: sum_exp=127, sum_mant=28'h8000000, in_state=OK, out_rdy=1 → result 32'h40000000, state 00, res_vld exactly 2 cycles after accept.
- RNE tie-up: exp=127, mant=28'h400000C → 32'h3F800002. Tie-even: mant=28'h4000004 → 32'h3F800000.
- Cancellation: exp=127, mant=28'h0000008 → 32'h34000000, state OK. mant=0 → 32'h00000000, state NUL.
- Overflow: exp=254, mant=28'h8000000, sign=1 → 32'hFF800000, state INF. in_state=NAN → 32'h7FC00000, state NAN.
- Backpressure: 4 back-to-back inputs, out_rdy=0 for 3 cycles:
  - in_rdy drops after 2 entries.
  - result stable while stalled.
  - all 4 results emerge in order once out_rdy=1.
- Reset mid-flight: pipe full, rst=0 for one cycle → res_vld=0, result=0, state=00, in_rdy=1; no stale results appear afterwards.
